// File: rtl/laser_tx_scheduler.sv
// Two-source byte scheduler for a laser transmitter: control bytes have priority over payload,
// with a transfer watchdog. Define LASER_TX_STARVE_GUARD_EN to bound payload starvation.
module laser_tx_scheduler #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic       clock_base,
  input  logic       reset,
  input  logic       ctrl_valid,
  input  logic [7:0] ctrl_byte,
  output logic       ctrl_ready,
  input  logic       pay_valid,
  input  logic [7:0] pay_byte,
  output logic       pay_ready,
  input  logic       link_enable,
  output logic [7:0] tx_byte,
  output logic       tx_load,
  output logic       tx_en,
  input  logic       tx_done,
  output logic       busy,
  output logic       grant_ctrl,
  output logic       timeout_err,
  output logic [7:0] timeout_count
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_DONE = 3'd2;
  localparam logic [2:0] ABORT     = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          idle, force_pay, ctrl_fire, pay_fire, timeout_hit;

  assign idle = (state == IDLE);

`ifdef LASER_TX_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // Counts back-to-back ctrl wins while payload waits; reaching the limit hands one slot to payload.
  always_ff @(posedge clock_base or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (ctrl_fire && pay_valid)
      starve_cnt <= starve_cnt + 1'b1;
    else if (ctrl_fire || pay_fire)
      starve_cnt <= '0;
  end

  assign force_pay = (starve_cnt == SW'(STARVE_LIMIT));
`else
  assign force_pay = 1'b0;
`endif

  assign ctrl_ready = idle & link_enable & ~force_pay;
  assign pay_ready  = idle & link_enable & (~ctrl_valid | force_pay);
  assign ctrl_fire  = ctrl_valid & ctrl_ready;
  assign pay_fire   = pay_valid & pay_ready;

  // tx_done outranks both a link drop and the watchdog on the same cycle.
  assign timeout_hit = (state == WAIT_DONE) & ~tx_done & link_enable &
                       (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (ctrl_fire || pay_fire) state_nxt = ISSUE;
      ISSUE:     state_nxt = link_enable ? WAIT_DONE : ABORT;
      WAIT_DONE: begin
        if (tx_done)          state_nxt = GAP;
        else if (!link_enable) state_nxt = ABORT;
        else if (timeout_hit) state_nxt = ABORT;
      end
      ABORT:     state_nxt = IDLE;
      GAP:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_base or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      tx_byte       <= 8'h00;
      grant_ctrl    <= 1'b0;
      timeout_err   <= 1'b0;
      timeout_count <= 8'h00;
    end else begin
      state       <= state_nxt;
      timeout_err <= timeout_hit;
      wait_cnt    <= (state == WAIT_DONE) ? wait_cnt + 1'b1 : '0;
      if (ctrl_fire) begin
        tx_byte    <= ctrl_byte;
        grant_ctrl <= 1'b1;
      end else if (pay_fire) begin
        tx_byte    <= pay_byte;
        grant_ctrl <= 1'b0;
      end
      if (timeout_hit && timeout_count != 8'hFF)
        timeout_count <= timeout_count + 8'd1;
    end
  end

  assign tx_load = (state == ISSUE);
  assign tx_en   = (state == ISSUE) | (state == WAIT_DONE) | (state == GAP);
  assign busy    = ~idle;

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// Randomized scoreboard bench for laser_tx_scheduler: a transaction-level model predicts each
// transmitted byte, its source, and how the transfer ends; a monitor checks every tx_load.
module tb_laser_tx_scheduler;
  localparam int TO = 16;
  localparam int SL = 4;

  logic       clock_base = 1'b0;
  logic       reset;
  logic       ctrl_valid, pay_valid, link_enable, tx_done;
  logic [7:0] ctrl_byte, pay_byte, tx_byte, timeout_count;
  logic       ctrl_ready, pay_ready, tx_load, tx_en, busy, grant_ctrl, timeout_err;

  int compared = 0;
  int mismatched = 0;

  // kind: 0 = completes, 1 = watchdog abort, 2 = link-drop abort, 3 = cut by reset
  typedef struct {
    logic [7:0] b;
    logic       gc;
    int         kind;
    int         blen;
    logic [7:0] tc;
  } exp_t;

  exp_t sbq[$];

  bit         c_pend, p_pend;
  logic [7:0] c_b, p_b;
  int         streak, tc_model;

  always #5 clock_base = ~clock_base;

  laser_tx_scheduler #(.TIMEOUT_CYCLES(TO), .STARVE_LIMIT(SL)) dut (
    .clock_base(clock_base), .reset(reset),
    .ctrl_valid(ctrl_valid), .ctrl_byte(ctrl_byte), .ctrl_ready(ctrl_ready),
    .pay_valid(pay_valid), .pay_byte(pay_byte), .pay_ready(pay_ready),
    .link_enable(link_enable),
    .tx_byte(tx_byte), .tx_load(tx_load), .tx_en(tx_en), .tx_done(tx_done),
    .busy(busy), .grant_ctrl(grant_ctrl), .timeout_err(timeout_err),
    .timeout_count(timeout_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clock_base);
      n++;
    end
    if (n >= 100) chk("idle_wait_expired", 1, 0);
  endtask

  // Offer the pending bytes, predict the winner, then finish the transfer by done / silence / link drop.
  task automatic xfer(input bit cv_new, input logic [7:0] cb, input bit pv_new, input logic [7:0] pb,
                      input int mode, input int d);
    bit   win_c, force_p, fc, fp;
    exp_t e;
    wait_idle();
    if (cv_new && !c_pend) begin c_pend = 1; c_b = cb; end
    if (pv_new && !p_pend) begin p_pend = 1; p_b = pb; end
    ctrl_valid = c_pend; ctrl_byte = c_b;
    pay_valid  = p_pend; pay_byte  = p_b;
    if (!c_pend && !p_pend) begin
      @(negedge clock_base);
      return;
    end
`ifdef LASER_TX_STARVE_GUARD_EN
    force_p = (streak == SL);
`else
    force_p = 1'b0;
`endif
    win_c = c_pend && !force_p;
    if (win_c && p_pend) streak++;
    else streak = 0;
    e.b    = win_c ? c_b : p_b;
    e.gc   = win_c;
    e.kind = mode;
    e.blen = (mode == 1) ? TO + 2 : d + 2;
    if (mode == 1 && tc_model < 255) tc_model++;
    e.tc = 8'(tc_model);
    sbq.push_back(e);
    #1;
    fc = ctrl_valid & ctrl_ready;
    fp = pay_valid & pay_ready;
    @(negedge clock_base);
    if (fc) begin ctrl_valid = 0; c_pend = 0; end
    if (fp) begin pay_valid = 0; p_pend = 0; end
    if (mode == 0) begin
      for (int k = 0; k < d; k++) begin
        if (k == 0 && $urandom_range(0, 1) == 1) tx_done = 1;  // must be ignored in ISSUE
        @(negedge clock_base);
        tx_done = 0;
      end
      tx_done = 1;
      @(negedge clock_base);
      tx_done = 0;
    end else if (mode == 2) begin
      repeat (d) @(negedge clock_base);
      link_enable = 0;
      wait_idle();
      repeat (2) begin
        chk("no_grant_link_low", {ctrl_ready, pay_ready, busy}, 0);
        @(negedge clock_base);
      end
      link_enable = 1;
    end
    wait_idle();
  endtask

  // Monitor: one scoreboard entry per tx_load; follows the transfer until busy drops.
  initial begin
    exp_t e;
    int   n, en_lo, loads, errs;
    forever begin
      @(negedge clock_base);
      if (reset === 1'b0 && tx_load === 1'b1) begin
        if (sbq.size() == 0) chk("unexpected_load", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("tx_byte", tx_byte, e.b);
          chk("grant_ctrl", grant_ctrl, e.gc);
          n = 0; en_lo = 0; loads = 0; errs = 0;
          do begin
            n++;
            en_lo += (tx_en === 1'b0) ? 1 : 0;
            loads += (tx_load === 1'b1) ? 1 : 0;
            errs  += (timeout_err === 1'b1) ? 1 : 0;
            @(negedge clock_base);
          end while (busy === 1'b1 && reset === 1'b0 && n < 64);
          if (e.kind != 3) begin
            chk("busy_cycles", n, e.blen);
            chk("tx_en_low_cycles", en_lo, (e.kind != 0) ? 1 : 0);
            chk("tx_load_pulses", loads, 1);
            chk("timeout_err_pulses", errs, (e.kind == 1) ? 1 : 0);
            chk("timeout_count", timeout_count, e.tc);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   r, mode, d;
    reset = 1; ctrl_valid = 0; pay_valid = 0; ctrl_byte = 0; pay_byte = 0;
    link_enable = 1; tx_done = 0;
    c_pend = 0; p_pend = 0; c_b = 0; p_b = 0; streak = 0; tc_model = 0;
    repeat (2) @(negedge clock_base);
    chk("rst_outputs", {tx_byte, tx_load, tx_en, grant_ctrl, busy, timeout_err, timeout_count}, 0);
    reset = 0;
    @(negedge clock_base);
    chk("idle_ready", {ctrl_ready, pay_ready}, 2'b11);

    // payload 0xA5, done 11 cycles after tx_load -> busy 13
    xfer(0, 8'h00, 1, 8'hA5, 0, 11);
    chk("pay_ready_back", pay_ready, 1);
    // simultaneous ctrl/pay: ctrl first, pay after
    xfer(1, 8'h11, 1, 8'h22, 0, 3);
    xfer(0, 8'h00, 0, 8'h00, 0, 4);
    // watchdog abort, then tx_done tied with the last watchdog cycle
    xfer(1, 8'h33, 0, 8'h00, 1, 0);
    xfer(1, 8'h77, 0, 8'h00, 0, TO);
    // both continuously valid: starvation pattern
    repeat (12) xfer(1, 8'($urandom), 1, 8'($urandom), 0, 1);
    while (c_pend || p_pend) xfer(0, 8'h00, 0, 8'h00, 0, 2);
    // link drop in WAIT_DONE and in ISSUE
    xfer(1, 8'h44, 0, 8'h00, 2, 5);
    xfer(0, 8'h00, 1, 8'h55, 2, 0);

    repeat (150) begin
      r = $urandom_range(0, 9);
      mode = (r < 6) ? 0 : (r < 8) ? 1 : 2;
      d = (mode == 0) ? $urandom_range(1, TO) : $urandom_range(0, TO - 1);
      xfer($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1, 8'($urandom), mode, d);
    end
    while (c_pend || p_pend) xfer(0, 8'h00, 0, 8'h00, 0, 2);

    // reset in WAIT_DONE: immediate reset values, then a clean transfer
    wait_idle();
    ctrl_valid = 1; ctrl_byte = 8'h5A;
    e.b = 8'h5A; e.gc = 1; e.kind = 3; e.blen = 0; e.tc = 0;
    sbq.push_back(e);
    @(negedge clock_base);
    ctrl_valid = 0;
    repeat (4) @(negedge clock_base);
    reset = 1;
    #1;
    chk("rst_mid_xfer", {tx_byte, tx_load, tx_en, grant_ctrl, busy, timeout_err, timeout_count}, 0);
    @(negedge clock_base);
    reset = 0;
    streak = 0; tc_model = 0;
    @(negedge clock_base);
    xfer(1, 8'h6B, 0, 8'h00, 0, 5);
    xfer(0, 8'h00, 1, 8'h7C, 1, 0);

    repeat (4) @(negedge clock_base);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/laser_tx_scheduler.md
LASER_TX_SCHEDULER -- requirements
Module: laser_tx_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max clock_base cycles in WAIT_DONE before abort.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive ctrl grants allowed while pay_valid is pending.
REQ-003 SHALL have port clock_base  input  1  clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high.
REQ-005 SHALL have ports ctrl_valid  input  1, ctrl_byte  input  8, ctrl_ready  output  1: the control/ACK requester.
REQ-006 SHALL have ports pay_valid  input  1, pay_byte  input  8, pay_ready  output  1: the payload requester.
REQ-007 SHALL have port link_enable  input  1  software enable for the laser link.
REQ-008 SHALL have ports tx_byte  output  8, tx_load  output  1, tx_en  output  1 to the laser transmitter's data byte, data-ready and enable.
REQ-009 SHALL have port tx_done  input  1  single-cycle completion pulse from the transmitter.
REQ-010 SHALL have ports busy  output  1, grant_ctrl  output  1 (1 = current byte from ctrl), timeout_err  output  1 (one-cycle pulse), timeout_count  output  8.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE, ABORT, GAP.
REQ-012 SHALL in IDLE drive ctrl_ready = link_enable, and pay_ready = link_enable & (~ctrl_valid | force_pay).
REQ-013 SHALL accept a byte on the cycle valid & ready, latch it into tx_byte, set grant_ctrl to the source, go to ISSUE; no other byte is accepted until IDLE returns.
REQ-014 SHALL, when both valid with force_pay low, grant ctrl only; pay_valid stays pending.
REQ-015 SHALL in ISSUE assert tx_load and tx_en for exactly one cycle, then go to WAIT_DONE.
REQ-016 SHALL in WAIT_DONE hold tx_en high, tx_load low, and count cycles from 0.
REQ-017 SHALL on tx_done in WAIT_DONE go to GAP (one cycle, tx_en high, tx_load low), then IDLE.
REQ-018 SHALL, when the count reaches TIMEOUT_CYCLES-1 without tx_done, go to ABORT, pulse timeout_err, and increment timeout_count, saturating at 255.
REQ-019 SHALL, if link_enable falls in ISSUE or WAIT_DONE, go to ABORT without timeout_err or count change.
REQ-020 SHALL tie tx_done to timeout if both arrive in the same cycle: tx_done wins, GAP.
REQ-021 SHALL in ABORT drive tx_en low for one cycle, then return to IDLE; the byte is dropped.
REQ-022 SHALL drive busy = (state != IDLE); ready outputs are low outside IDLE.
REQ-023 SHALL ignore tx_done outside WAIT_DONE.

Reset
REQ-024 SHALL on reset asynchronously enter IDLE with tx_byte=0, tx_load=0, tx_en=0, grant_ctrl=0, busy=0, timeout_err=0, timeout_count=0, and the starvation counter at 0.
REQ-025 SHALL on reset mid-transfer drop the in-flight byte and not signal completion.

Configuration
REQ-026 SHALL, with LASER_TX_STARVE_GUARD_EN defined, keep a starvation counter:
- incremented on each ctrl grant while pay_valid is high
- cleared on a pay grant, or on a ctrl grant with pay_valid low
- force_pay = (counter == STARVE_LIMIT)
- while force_pay is high, ctrl_ready is low
REQ-027 SHALL, without LASER_TX_STARVE_GUARD_EN, tie force_pay to 0 and not implement the counter (strict ctrl priority).

Verification
REQ-028 SHALL cover: pay_valid, pay_byte=0xA5, tx_done 11 cycles after tx_load -> tx_byte=0xA5, one tx_load pulse, busy for 13 cycles, pay_ready again in IDLE.
REQ-029 SHALL cover: ctrl 0x11 and pay 0x22 valid same cycle -> 0x11 sent first with grant_ctrl=1, then 0x22 with grant_ctrl=0.
REQ-030 SHALL cover: TIMEOUT_CYCLES=16, tx_done never arrives -> ABORT on the 16th WAIT_DONE cycle, one timeout_err pulse, timeout_count=1, tx_en low one cycle.
REQ-031 SHALL cover: guard enabled, STARVE_LIMIT=4, ctrl and pay continuously valid -> grant pattern C,C,C,C,P repeating; guard disabled -> ctrl only.
REQ-032 SHALL cover: link_enable dropped during WAIT_DONE -> ABORT, timeout_err stays 0, no new grant until link_enable returns.
REQ-033 SHALL cover: reset asserted in WAIT_DONE -> all outputs immediately at reset values, then a normal transfer after reset release.
